// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared constants and types for the fetch stage and its branch predictor:
// opcode values, the NOP word, the 2-bit saturating counter encoding with its
// reset value, and the counter update function.
// Optional feature macro used by the fetch files: FETCH_BTB_TAG_EN.
package fetch_pkg;

  localparam logic [3:0]  OP_HLT   = 4'hF;
  localparam logic [3:0]  OP_B     = 4'hC;
  localparam logic [3:0]  OP_BR    = 4'hD;
  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } bht_cnt_t;

  localparam bht_cnt_t CNT_RESET = CNT_WNT;

  function automatic bht_cnt_t sat_update(input bht_cnt_t cnt, input logic taken);
    bht_cnt_t res;
    res = cnt;
    if (taken) begin
      if (cnt != CNT_ST) res = bht_cnt_t'(cnt + 2'd1);
    end else begin
      if (cnt != CNT_SNT) res = bht_cnt_t'(cnt - 2'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_predictor.sv
// branch_predictor
// 2-bit-counter BHT plus direct-mapped BTB, indexed by pc[BHT_BITS:1].
// Optional macro FETCH_BTB_TAG_EN: when defined the BTB keeps pc[15:BHT_BITS+1]
// as a tag and a hit requires valid and tag match; otherwise hit = valid and
// aliasing branches share an entry.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   lookup_pc       fetch PC being predicted (combinational lookup)
//   pred_taken      counter MSB qualified by BTB hit
//   pred_target     stored target for the looked-up entry
//   upd_en          train this cycle
//   upd_pc          PC of the resolved branch
//   upd_taken       resolved direction
//   upd_target      resolved target
module branch_predictor
  import fetch_pkg::*;
#(
  parameter int BHT_BITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] lookup_pc,
  output logic        pred_taken,
  output logic [15:0] pred_target,
  input  logic        upd_en,
  input  logic [15:0] upd_pc,
  input  logic        upd_taken,
  input  logic [15:0] upd_target
);

  localparam int ENTRIES = 1 << BHT_BITS;

  bht_cnt_t            bht [ENTRIES];
  logic [ENTRIES-1:0]  btb_valid;
  logic [15:0]         btb_target [ENTRIES];

  logic [BHT_BITS-1:0] lk_idx;
  logic [BHT_BITS-1:0] up_idx;
  logic [1:0]          lk_cnt;
  logic                btb_hit;

  assign lk_idx = lookup_pc[BHT_BITS:1];
  assign up_idx = upd_pc[BHT_BITS:1];
  assign lk_cnt = bht[lk_idx];

`ifdef FETCH_BTB_TAG_EN
  localparam int TAG_W = 15 - BHT_BITS;

  logic [TAG_W-1:0] btb_tag [ENTRIES];
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{lookup_pc[0], upd_pc[0]};
  assign btb_hit = btb_valid[lk_idx] && (btb_tag[lk_idx] == lookup_pc[15:BHT_BITS+1]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) btb_tag[i] <= '0;
    end else if (upd_en && upd_taken) begin
      btb_tag[up_idx] <= upd_pc[15:BHT_BITS+1];
    end
  end
`else
  logic unused_pc_bits;

  assign unused_pc_bits = ^{lookup_pc[15:BHT_BITS+1], lookup_pc[0],
                            upd_pc[15:BHT_BITS+1], upd_pc[0]};
  assign btb_hit = btb_valid[lk_idx];
`endif

  // Lookup reads the array state before this edge's update: no bypass.
  assign pred_taken  = lk_cnt[1] & btb_hit;
  assign pred_target = btb_target[lk_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i]        <= CNT_RESET;
        btb_target[i] <= '0;
      end
      btb_valid <= '0;
    end else if (upd_en) begin
      bht[up_idx] <= sat_update(bht[up_idx], upd_taken);
      if (upd_taken) begin
        btb_valid[up_idx]  <= 1'b1;
        btb_target[up_idx] <= upd_target;
      end
    end
  end

endmodule

// File: rtl/fetch_predict.sv
// fetch_predict
// Instruction fetch stage: PC register, next-PC selection with dynamic
// branch prediction, and the IF/ID pipeline register. Decode's branch
// resolution trains the predictor and redirects/flushes on a misprediction
// or on a predicted-taken branch whose target turned out wrong.
// Optional macro FETCH_BTB_TAG_EN (handled in branch_predictor) enables BTB tags.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   stall                    hold PC, IF/ID and predictor training
//   instr                    instruction word at pc_curr
//   ID_is_branch, ID_taken   decode holds a branch / its resolved direction
//   ID_misprediction         resolved direction differs from prediction
//   ID_Branch_target         resolved target
//   pc_curr                  fetch address
//   IF_ID_*                  registered instruction, PC+2, PC, prediction
module fetch_predict
  import fetch_pkg::*;
#(
  parameter int BHT_BITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [15:0] instr,
  input  logic        ID_is_branch,
  input  logic        ID_taken,
  input  logic        ID_misprediction,
  input  logic [15:0] ID_Branch_target,
  output logic [15:0] pc_curr,
  output logic [15:0] IF_ID_pc_inst,
  output logic [15:0] IF_ID_pc_next,
  output logic [15:0] IF_ID_pc_curr,
  output logic        IF_ID_predicted_taken,
  output logic [15:0] IF_ID_predicted_target
);

  logic [15:0] pc_plus2;
  logic [15:0] pc_nxt;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        is_hlt;
  logic        tgt_miss;
  logic        redirect;
  logic        train_en;

  assign pc_plus2 = pc_curr + 16'd2;
  assign is_hlt   = (instr[15:12] == OP_HLT);

  // Direction was right (taken/taken) but the BTB supplied a stale target.
  assign tgt_miss = ID_is_branch & ID_taken & IF_ID_predicted_taken &
                    (IF_ID_predicted_target != ID_Branch_target);
  assign redirect = ~stall & ID_is_branch & (ID_misprediction | tgt_miss);
  assign train_en = ~stall & ID_is_branch;

  branch_predictor #(.BHT_BITS(BHT_BITS)) u_bp (
    .clk         (clk),
    .rst         (rst),
    .lookup_pc   (pc_curr),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_en      (train_en),
    .upd_pc      (IF_ID_pc_curr),
    .upd_taken   (ID_taken),
    .upd_target  (ID_Branch_target)
  );

  // Redirect outranks HLT so a halted fetch can still be steered away.
  always_comb begin
    pc_nxt = pc_plus2;
    if (redirect)        pc_nxt = ID_taken ? ID_Branch_target : IF_ID_pc_next;
    else if (is_hlt)     pc_nxt = pc_curr;
    else if (pred_taken) pc_nxt = pred_target;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_curr                <= 16'h0000;
      IF_ID_pc_inst          <= NOP_WORD;
      IF_ID_pc_next          <= 16'h0000;
      IF_ID_pc_curr          <= 16'h0000;
      IF_ID_predicted_taken  <= 1'b0;
      IF_ID_predicted_target <= 16'h0000;
    end else if (!stall) begin
      pc_curr <= pc_nxt;
      if (redirect) begin
        IF_ID_pc_inst          <= NOP_WORD;
        IF_ID_pc_next          <= 16'h0000;
        IF_ID_pc_curr          <= 16'h0000;
        IF_ID_predicted_taken  <= 1'b0;
        IF_ID_predicted_target <= 16'h0000;
      end else begin
        IF_ID_pc_inst          <= instr;
        IF_ID_pc_next          <= pc_plus2;
        IF_ID_pc_curr          <= pc_curr;
        IF_ID_predicted_taken  <= pred_taken;
        IF_ID_predicted_target <= pred_target;
      end
    end
  end

endmodule
